// File: rtl/lsu_writeback_if.sv
// Data-memory bus between the LSU/writeback stage (master) and the memory (slave):
// a valid/ready request channel and a valid-only response channel.
interface lsu_writeback_if #(
  parameter int WIDTH = 32
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_rsp_valid;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_writeback.sv
// Memory-access and writeback stage: takes one executed instruction, performs
// its load/store on the data bus if needed, and retires it to the register file.
module lsu_writeback #(
  parameter int WIDTH     = 32,
  parameter int INDEX_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mem,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [INDEX_LEN:0] req_rd,
  lsu_writeback_if.master    mem,
  output logic               RegWEn,
  output logic [INDEX_LEN:0] RegWriteIndex,
  output logic [WIDTH-1:0]   RegWriteData,
  output logic               done,
  output logic               misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t               state_reg, state_next;
  logic                 accept;
  logic                 illegal, misaligned, fault_next;
  logic [WIDTH-1:0]     st_wdata;
  logic [3:0]           st_wstrb;

  logic                 store_reg, fault_reg;
  logic [2:0]           funct3_reg;
  logic [1:0]           offset_reg;
  logic [WIDTH-1:0]     addr_reg, wdata_reg, result_reg;
  logic [3:0]           wstrb_reg;
  logic [INDEX_LEN:0]   rd_reg;

  logic [WIDTH-1:0]     lane, load_data;
  logic                 wb_write;

  // Ready is gated by reset so the stage advertises nothing while held in reset.
  assign req_ready = rst & (state_reg == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    if (req_store)
      illegal = req_funct3[2] | (req_funct3 == 3'b011);
    else
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
               | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    fault_next = req_mem & (illegal | misaligned);
  end

  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign lane = mem.mem_rdata >> {offset_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
      3'b001:  load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      store_reg  <= 1'b0;
      fault_reg  <= 1'b0;
      funct3_reg <= 3'b000;
      offset_reg <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= 4'b0000;
      rd_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        store_reg  <= req_mem & req_store;
        fault_reg  <= fault_next;
        funct3_reg <= req_funct3;
        offset_reg <= req_addr[1:0];
        addr_reg   <= {req_addr[WIDTH-1:2], 2'b00};
        wdata_reg  <= st_wdata;
        wstrb_reg  <= st_wstrb;
        rd_reg     <= req_rd;
        result_reg <= req_addr;
      end else if (state_reg == WAIT && mem.mem_rsp_valid) begin
        // Load result captured here so write data stays stable through WB.
        result_reg <= load_data;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    mem.mem_req_valid = 1'b0;
    mem.mem_addr      = '0;
    mem.mem_we        = 1'b0;
    mem.mem_wdata     = '0;
    mem.mem_wstrb     = 4'b0000;
    done              = 1'b0;
    misalign_err      = 1'b0;
    wb_write          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept)
          state_next = (!req_mem || fault_next) ? WB : REQ;
      end
      REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_addr      = addr_reg;
        mem.mem_we        = store_reg;
        mem.mem_wdata     = wdata_reg;
        mem.mem_wstrb     = wstrb_reg;
        if (mem.mem_req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (mem.mem_rsp_valid)
          state_next = WB;
      end
      WB: begin
        done         = 1'b1;
        misalign_err = fault_reg;
        wb_write     = ~store_reg & ~fault_reg & (rd_reg != '0);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign RegWEn        = wb_write;
  assign RegWriteIndex = wb_write ? rd_reg : '0;
  assign RegWriteData  = wb_write ? result_reg : '0;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback: directed vector table, randomized ops
// against a reference model, and a reset-during-WAIT sequence.
module tb_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mem = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        RegWEn;
  logic [4:0]  RegWriteIndex;
  logic [31:0] RegWriteData;
  logic        done;
  logic        misalign_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_writeback_if #(.WIDTH(32)) mem_bus ();

  lsu_writeback #(.WIDTH(32), .INDEX_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mem       (req_mem),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem           (mem_bus.master),
    .RegWEn        (RegWEn),
    .RegWriteIndex (RegWriteIndex),
    .RegWriteData  (RegWriteData),
    .done          (done),
    .misalign_err  (misalign_err)
  );

  typedef struct packed {
    logic        mem;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  req_dly;
    logic [3:0]  rsp_dly;
  } op_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  wstrb;
    logic        regwen;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
    logic [7:0]  cycle;
  } exp_t;

  typedef struct packed {
    logic        ready;
    logic [7:0]  req_cycles;
    logic        unstable;
    logic [31:0] maddr;
    logic        we;
    logic [31:0] mwdata;
    logic [3:0]  wstrb;
    logic        regwen;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
    logic [7:0]  cycle;
    logic        after_done;
    logic        after_ready;
  } obs_t;

  typedef struct packed {
    op_t  op;
    exp_t e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: derived from access size and byte offset with plain arithmetic.
  function automatic exp_t model(input op_t op);
    exp_t        e;
    int          size, off;
    bit          legal, mis;
    logic [63:0] one, mask64;
    logic [31:0] mask, v;
    e      = '0;
    size   = 1 << op.f3[1:0];
    off    = int'(op.addr % 4);
    one    = 64'd1;
    mask64 = (one << (8 * size)) - 1;
    mask   = mask64[31:0];
    if (!op.mem) begin
      e.regwen = (op.rd != 0);
      e.data   = op.addr;
      e.cycle  = 8'd1;
    end else begin
      if (op.store) legal = (op.f3 == 0) || (op.f3 == 1) || (op.f3 == 2);
      else legal = (op.f3 == 0) || (op.f3 == 1) || (op.f3 == 2) || (op.f3 == 4) || (op.f3 == 5);
      mis = (size <= 4) && ((op.addr % size) != 0);
      if (!legal || mis) begin
        e.err   = 1'b1;
        e.cycle = 8'd1;
      end else begin
        e.req   = 1'b1;
        e.we    = op.store;
        e.maddr = op.addr - (op.addr % 4);
        e.cycle = 8'(3 + op.req_dly + op.rsp_dly);
        if (op.store) begin
          if (size == 1) e.mwdata = (op.wdata & 32'hFF) * 32'h0101_0101;
          else if (size == 2) e.mwdata = (op.wdata & 32'hFFFF) * 32'h0001_0001;
          else e.mwdata = op.wdata;
          e.wstrb = 4'(((1 << size) - 1) << off);
        end else begin
          v = (op.rdata >> (8 * off)) & mask;
          if (!op.f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
          e.regwen = (op.rd != 0);
          e.data   = v;
        end
      end
    end
    if (!e.regwen) begin
      e.idx  = '0;
      e.data = '0;
    end else begin
      e.idx = op.rd;
    end
    return e;
  endfunction

  // Called at a negedge with the stage idle; returns at a negedge, idle again.
  task automatic run_op(input op_t op, output obs_t o);
    bit hs;
    int req_cnt, rsp_cnt;
    o = '0; hs = 0; req_cnt = 0; rsp_cnt = 0;
    req_valid  = 1'b1;
    req_mem    = op.mem;
    req_store  = op.store;
    req_funct3 = op.f3;
    req_addr   = op.addr;
    req_wdata  = op.wdata;
    req_rd     = op.rd;
    #1 o.ready = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_mem    = 1'($urandom);
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
    for (int k = 1; k <= 40; k++) begin
      mem_bus.mem_req_ready = 1'b0;
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rdata     = $urandom;
      if (mem_bus.mem_req_valid) begin
        if (o.req_cycles == 0) begin
          o.maddr  = mem_bus.mem_addr;
          o.we     = mem_bus.mem_we;
          o.mwdata = mem_bus.mem_wdata;
          o.wstrb  = mem_bus.mem_wstrb;
        end else if (o.maddr !== mem_bus.mem_addr || o.we !== mem_bus.mem_we ||
                     o.mwdata !== mem_bus.mem_wdata || o.wstrb !== mem_bus.mem_wstrb) begin
          o.unstable = 1'b1;
        end
        o.req_cycles++;
        if (req_cnt == int'(op.req_dly)) begin
          mem_bus.mem_req_ready = 1'b1;
          hs = 1;
        end else begin
          mem_bus.mem_rsp_valid = 1'($urandom_range(0, 1)); // stray, must be ignored
        end
        req_cnt++;
      end else if (hs) begin
        if (rsp_cnt == int'(op.rsp_dly)) begin
          mem_bus.mem_rsp_valid = 1'b1;
          mem_bus.mem_rdata     = op.rdata;
        end
        rsp_cnt++;
      end
      if (done) begin
        o.regwen = RegWEn;
        o.idx    = RegWriteIndex;
        o.data   = RegWriteData;
        o.err    = misalign_err;
        o.cycle  = 8'(k);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o.after_done  = done;
    o.after_ready = req_ready;
  endtask

  task automatic compare(input string tag, input op_t op, input exp_t e, input obs_t o);
    check($sformatf("%s req_ready", tag), 32'(o.ready), 32'd1);
    check($sformatf("%s req_cycles", tag), 32'(o.req_cycles), e.req ? 32'(op.req_dly) + 1 : 32'd0);
    if (e.req) begin
      check($sformatf("%s mem_addr", tag), o.maddr, e.maddr);
      check($sformatf("%s mem_we", tag), 32'(o.we), 32'(e.we));
      check($sformatf("%s req_stable", tag), 32'(o.unstable), 32'd0);
      if (e.we) begin
        check($sformatf("%s mem_wdata", tag), o.mwdata, e.mwdata);
        check($sformatf("%s mem_wstrb", tag), 32'(o.wstrb), 32'(e.wstrb));
      end
    end
    check($sformatf("%s done_cycle", tag), 32'(o.cycle), 32'(e.cycle));
    check($sformatf("%s RegWEn", tag), 32'(o.regwen), 32'(e.regwen));
    check($sformatf("%s RegWriteIndex", tag), 32'(o.idx), 32'(e.idx));
    check($sformatf("%s RegWriteData", tag), o.data, e.data);
    check($sformatf("%s misalign_err", tag), 32'(o.err), 32'(e.err));
    check($sformatf("%s done_pulse", tag), 32'(o.after_done), 32'd0);
    check($sformatf("%s ready_after", tag), 32'(o.after_ready), 32'd1);
    $display("%s: mem=%0b st=%0b f3=%0d addr=%08h rd=%0d -> cyc=%0d we=%0b idx=%0d data=%08h err=%0b",
             tag, op.mem, op.store, op.f3, op.addr, op.rd, o.cycle, o.regwen, o.idx, o.data, o.err);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s req_ready", tag), 32'(req_ready), 32'd0);
    check($sformatf("%s mem_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    check($sformatf("%s mem_addr", tag), mem_bus.mem_addr, 32'd0);
    check($sformatf("%s mem_we", tag), 32'(mem_bus.mem_we), 32'd0);
    check($sformatf("%s mem_wdata", tag), mem_bus.mem_wdata, 32'd0);
    check($sformatf("%s mem_wstrb", tag), 32'(mem_bus.mem_wstrb), 32'd0);
    check($sformatf("%s RegWEn", tag), 32'(RegWEn), 32'd0);
    check($sformatf("%s RegWriteIndex", tag), 32'(RegWriteIndex), 32'd0);
    check($sformatf("%s RegWriteData", tag), RegWriteData, 32'd0);
    check($sformatf("%s done", tag), 32'(done), 32'd0);
    check($sformatf("%s misalign_err", tag), 32'(misalign_err), 32'd0);
  endtask

  function automatic op_t mk_op(input logic m, input logic s, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                                input logic [31:0] rdata, input logic [3:0] qd, input logic [3:0] sd);
    return '{mem: m, store: s, f3: f3, addr: a, wdata: wd, rd: rd, rdata: rdata, req_dly: qd, rsp_dly: sd};
  endfunction

  function automatic exp_t mk_exp(input logic rq, input logic we, input logic [31:0] ma,
                                  input logic [31:0] mw, input logic [3:0] ws, input logic wen,
                                  input logic [4:0] idx, input logic [31:0] d, input logic err,
                                  input logic [7:0] cyc);
    return '{req: rq, we: we, maddr: ma, mwdata: mw, wstrb: ws, regwen: wen, idx: idx,
             data: d, err: err, cycle: cyc};
  endfunction

  vec_t vecs[15];
  op_t  op;
  exp_t e;
  obs_t o;

  initial begin
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata     = '0;

    // Hand-computed expectations for the directed cases.
    vecs[0]  = '{mk_op(0,0,3'b000,32'h1234_5678,0,5,0,0,0),            mk_exp(0,0,0,0,0,1,5,32'h1234_5678,0,1)};
    vecs[1]  = '{mk_op(1,0,3'b000,32'h8000_0003,0,7,32'h80FF_7F01,2,2), mk_exp(1,0,32'h8000_0000,0,0,1,7,32'hFFFF_FF80,0,7)};
    vecs[2]  = '{mk_op(1,0,3'b100,32'h8000_0003,0,7,32'h80FF_7F01,2,2), mk_exp(1,0,32'h8000_0000,0,0,1,7,32'h0000_0080,0,7)};
    vecs[3]  = '{mk_op(1,1,3'b001,32'h0000_0102,32'hAAAA_BEEF,9,0,0,0), mk_exp(1,1,32'h0000_0100,32'hBEEF_BEEF,4'b1100,0,0,0,0,3)};
    vecs[4]  = '{mk_op(1,0,3'b010,32'h0000_0016,0,4,0,0,0),            mk_exp(0,0,0,0,0,0,0,0,1,1)};
    vecs[5]  = '{mk_op(1,0,3'b010,32'h0000_0040,0,0,32'hDEAD_BEEF,0,0), mk_exp(1,0,32'h0000_0040,0,0,0,0,0,0,3)};
    vecs[6]  = '{mk_op(1,1,3'b000,32'h0000_0201,32'h1234_56A5,1,0,1,0), mk_exp(1,1,32'h0000_0200,32'hA5A5_A5A5,4'b0010,0,0,0,0,4)};
    vecs[7]  = '{mk_op(1,0,3'b001,32'h0000_0302,0,10,32'h8001_1234,0,1), mk_exp(1,0,32'h0000_0300,0,0,1,10,32'hFFFF_8001,0,4)};
    vecs[8]  = '{mk_op(1,0,3'b101,32'h0000_0302,0,10,32'h8001_1234,0,1), mk_exp(1,0,32'h0000_0300,0,0,1,10,32'h0000_8001,0,4)};
    vecs[9]  = '{mk_op(1,0,3'b011,32'h0000_0000,0,2,0,0,0),            mk_exp(0,0,0,0,0,0,0,0,1,1)};
    vecs[10] = '{mk_op(1,1,3'b100,32'h0000_0000,0,2,0,0,0),            mk_exp(0,0,0,0,0,0,0,0,1,1)};
    vecs[11] = '{mk_op(1,1,3'b010,32'h0000_0408,32'hCAFE_F00D,3,0,0,0), mk_exp(1,1,32'h0000_0408,32'hCAFE_F00D,4'b1111,0,0,0,0,3)};
    vecs[12] = '{mk_op(1,1,3'b001,32'h0000_0001,32'h1111_2222,3,0,0,0), mk_exp(0,0,0,0,0,0,0,0,1,1)};
    vecs[13] = '{mk_op(1,0,3'b010,32'h0000_001C,0,31,32'h1357_9BDF,3,0), mk_exp(1,0,32'h0000_001C,0,0,1,31,32'h1357_9BDF,0,6)};
    vecs[14] = '{mk_op(1,0,3'b000,32'h0000_0020,0,6,32'h0000_007F,0,0), mk_exp(1,0,32'h0000_0020,0,0,1,6,32'h0000_007F,0,3)};

    // Outputs while held in reset.
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_reset req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i])
      begin
        run_op(vecs[i].op, o);
        compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, o);
      end

    for (int i = 0; i < 150; i++) begin
      op.mem     = ($urandom_range(0, 3) != 0);
      op.store   = 1'($urandom);
      op.f3      = 3'($urandom);
      op.addr    = $urandom;
      op.wdata   = $urandom;
      op.rd      = 5'($urandom);
      op.rdata   = $urandom;
      op.req_dly = 4'($urandom_range(0, 3));
      op.rsp_dly = 4'($urandom_range(0, 3));
      e = model(op);
      run_op(op, o);
      compare($sformatf("rand%0d", i), op, e, o);
    end

    // Reset while waiting for a load response; a late response must not retire.
    req_valid  = 1'b1;
    req_mem    = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0100;
    req_rd     = 5'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_seq req_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    mem_bus.mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    check("rst_seq in_wait", 32'(mem_bus.mem_req_valid | done), 32'd0);
    rst = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_release req_ready", 32'(req_ready), 32'd1);
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rdata     = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("late_rsp%0d done", k), 32'(done), 32'd0);
      check($sformatf("late_rsp%0d RegWEn", k), 32'(RegWEn), 32'd0);
      check($sformatf("late_rsp%0d req_ready", k), 32'(req_ready), 32'd1);
    end
    mem_bus.mem_rsp_valid = 1'b0;
    $display("reset during WAIT: late response ignored, req_ready=%0b", req_ready);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
